// File: rtl/bus_fifo_regs_pkg.sv
// Shared register map and STATUS bit positions for the FIFO-backed bus registers.
package bus_fifo_regs_pkg;

  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  localparam int STAT_TX_FULL = 0;
  localparam int STAT_RX_NE   = 1;
  localparam int STAT_ERR     = 2;

endpackage

// File: rtl/bus_fifo_regs_if.sv
// Bundle of bus-slave strobes, fabric streams and FIFO fill levels for bus_fifo_regs.
// Stream handshake: a word moves when valid and ready are both high at a rising clk;
// ready never depends on valid, and data is only meaningful while valid is high.
interface bus_fifo_regs_if #(
  parameter int DATW       = 3,
  parameter int DEPTH_LOG2 = 3
);
  logic            do_write;
  logic            do_read;
  logic            rw_adr;
  logic [DATW-1:0] w_data;
  logic [DATW-1:0] read_data;

  logic [DATW-1:0] tx_data;
  logic            tx_valid;
  logic            tx_ready;
  logic [DATW-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ready;

  logic [DEPTH_LOG2:0] tx_count;
  logic [DEPTH_LOG2:0] rx_count;

  modport master (
    output do_write, do_read, rw_adr, w_data, tx_ready, rx_data, rx_valid,
    input  read_data, tx_data, tx_valid, rx_ready, tx_count, rx_count
  );

  modport slave (
    input  do_write, do_read, rw_adr, w_data, tx_ready, rx_data, rx_valid,
    output read_data, tx_data, tx_valid, rx_ready, tx_count, rx_count
  );
endinterface

// File: rtl/bus_fifo_regs_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module bus_fifo_regs_sync_fifo #(
  parameter int W          = 3,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        din,
  output logic [W-1:0]        dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  assign full    = count[DEPTH_LOG2];
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: emptiness is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/bus_fifo_regs.sv
// DATA/STATUS register pair backed by a TX FIFO (MCU to fabric) and an RX FIFO (fabric to MCU).
module bus_fifo_regs
  import bus_fifo_regs_pkg::*;
#(
  parameter int DATW       = 3,
  parameter int DEPTH_LOG2 = 3
) (
  input logic             clk,
  input logic             rst,
  bus_fifo_regs_if.slave  bus
);
  logic            wr_data;
  logic            rd_data;
  logic            wr_stat;
  logic            tx_pop;
  logic            tx_full;
  logic            tx_empty;
  logic [DATW-1:0] tx_dout;
  logic            rx_push;
  logic            rx_full;
  logic            rx_empty;
  logic [DATW-1:0] rx_dout;
  logic            err;
  logic            err_set;
  logic            err_clr;
  logic [DATW-1:0] status;

  assign wr_data = bus.do_write & (bus.rw_adr == ADR_DATA);
  assign rd_data = bus.do_read  & (bus.rw_adr == ADR_DATA);
  assign wr_stat = bus.do_write & (bus.rw_adr == ADR_STATUS);

  assign tx_pop  = ~tx_empty & bus.tx_ready;
  assign rx_push = bus.rx_valid & ~rx_full;

  bus_fifo_regs_sync_fifo #(.W(DATW), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (tx_pop),
    .din   (bus.w_data),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (bus.tx_count)
  );

  bus_fifo_regs_sync_fifo #(.W(DATW), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rd_data),
    .din   (bus.rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .count (bus.rx_count)
  );

  // Dropped TX write or DATA read from an empty RX FIFO; set beats clear.
  assign err_set = (wr_data & tx_full & ~tx_pop) | (rd_data & rx_empty);
  assign err_clr = wr_stat & bus.w_data[STAT_ERR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  always_comb begin
    status               = '0;
    status[STAT_TX_FULL] = tx_full;
    status[STAT_RX_NE]   = ~rx_empty;
    status[STAT_ERR]     = err;
  end

  assign bus.read_data = (bus.rw_adr == ADR_DATA) ? rx_dout : status;
  assign bus.tx_data   = tx_dout;
  assign bus.tx_valid  = ~tx_empty;
  assign bus.rx_ready  = ~rx_full;
endmodule

// File: tb/tb_bus_fifo_regs.sv
// Bench for bus_fifo_regs: vector table, directed corner sequences, then random traffic vs a queue model.
module tb_bus_fifo_regs;
  localparam int DATW  = 3;
  localparam int DL    = 3;
  localparam int DEPTH = 8;

  typedef struct {
    logic            wr;
    logic            rd;
    logic            adr;
    logic [DATW-1:0] wdata;
    logic [DATW-1:0] exp_rdata;
    logic            exp_tx_valid;
    logic            exp_rx_ready;
  } vec_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [DATW-1:0] exp_q[$];

  bus_fifo_regs_if #(.DATW(DATW), .DEPTH_LOG2(DL)) bus ();

  bus_fifo_regs #(.DATW(DATW), .DEPTH_LOG2(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic adr, input logic [DATW-1:0] d);
    @(negedge clk);
    bus.do_write = 1'b1;
    bus.rw_adr   = adr;
    bus.w_data   = d;
    @(negedge clk);
    bus.do_write = 1'b0;
  endtask

  task automatic bus_read(input logic adr, output logic [DATW-1:0] d);
    @(negedge clk);
    bus.do_read = 1'b1;
    bus.rw_adr  = adr;
    #1 d = bus.read_data;
    @(negedge clk);
    bus.do_read = 1'b0;
  endtask

  task automatic rx_push(input logic [DATW-1:0] d);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t            vecs[12];
    logic [DATW-1:0] ovf_d[9];
    logic [DATW-1:0] rd;
    logic [DATW-1:0] tx_m[$];
    logic [DATW-1:0] rx_m[$];
    logic            err_m;
    logic [DATW-1:0] stat;
    logic            exp_txv;
    logic            exp_rxr;
    logic            set_err;
    int              op;
    int              rdy_lim;
    int              vld_lim;

    bus.do_write = 1'b0;
    bus.do_read  = 1'b0;
    bus.rw_adr   = 1'b0;
    bus.w_data   = '0;
    bus.tx_ready = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;

    ovf_d = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
    vecs[0] = '{1'b0, 1'b1, 1'b1, 3'd0, 3'b000, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++)
      vecs[i+1] = '{1'b1, 1'b0, 1'b0, ovf_d[i], 3'd0, (i > 0), 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 3'd0, 3'b101, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd0,   1'b1, 1'b1};

    do_reset();
    #1;
    check("reset_tx_valid", bus.tx_valid, 1'b0);
    check("reset_tx_data",  bus.tx_data,  3'd0);
    check("reset_rx_ready", bus.rx_ready, 1'b1);
    check("reset_read_data0", bus.read_data, 3'd0);

    // TX overflow via vector table (tx_ready held low)
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.do_write = vecs[i].wr;
      bus.do_read  = vecs[i].rd;
      bus.rw_adr   = vecs[i].adr;
      bus.w_data   = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_read_data", i), bus.read_data, vecs[i].exp_rdata);
      check($sformatf("vec%0d_tx_valid", i),  bus.tx_valid,  vecs[i].exp_tx_valid);
      check($sformatf("vec%0d_rx_ready", i),  bus.rx_ready,  vecs[i].exp_rx_ready);
    end
    @(negedge clk);
    bus.do_write = 1'b0;
    bus.do_read  = 1'b0;

    // Drain TX: 9th value must have been dropped
    for (int i = 0; i < 8; i++) exp_q.push_back(ovf_d[i]);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain%0d_tx_valid", i), bus.tx_valid, 1'b1);
      check($sformatf("drain%0d_tx_data", i),  bus.tx_data,  exp_q.pop_front());
      @(negedge clk);
    end
    #1;
    check("drained_tx_valid", bus.tx_valid, 1'b0);
    check("drained_tx_data",  bus.tx_data,  3'd0);
    bus.tx_ready = 1'b0;
    bus_read(1'b1, rd);
    check("status_after_drain", rd, 3'b100);
    bus_write(1'b1, 3'b100);
    bus_read(1'b1, rd);
    check("status_err_cleared", rd, 3'b000);

    // RX path and underflow
    rx_push(3'd5);
    rx_push(3'd6);
    bus_read(1'b0, rd); check("rx_read0", rd, 3'd5);
    bus_read(1'b0, rd); check("rx_read1", rd, 3'd6);
    bus_read(1'b0, rd); check("rx_underflow_read", rd, 3'd0);
    bus_read(1'b1, rd); check("status_underflow", rd, 3'b100);
    bus_write(1'b1, 3'b100);
    bus_read(1'b1, rd); check("status_underflow_clr", rd, 3'b000);

    // RX full, then a DATA read with the producer still offering a word
    for (int i = 0; i < DEPTH; i++) rx_push(3'(i + 1));
    #1;
    check("rx_full_ready", bus.rx_ready, 1'b0);
    check("rx_full_count", bus.rx_count, 4'd8);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 3'd3;
    bus.do_read  = 1'b1;
    bus.rw_adr   = 1'b0;
    #1;
    check("rx_full_read_data", bus.read_data, 3'd1);
    check("rx_full_ready_during_read", bus.rx_ready, 1'b0);
    @(negedge clk);
    bus.do_read = 1'b0;
    #1;
    check("rx_ready_after_read", bus.rx_ready, 1'b1);
    check("rx_count_after_read", bus.rx_count, 4'd7);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1;
    check("rx_refilled_ready", bus.rx_ready, 1'b0);
    check("rx_refilled_count", bus.rx_count, 4'd8);
    exp_q = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd3};
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(1'b0, rd);
      check($sformatf("rx_full_drain%0d", i), rd, exp_q.pop_front());
    end
    bus_read(1'b1, rd);
    check("status_after_rx_full", rd, 3'b000);

    // Asynchronous reset with both FIFOs partly filled
    for (int i = 0; i < 4; i++) bus_write(1'b0, 3'(i + 2));
    for (int i = 0; i < 4; i++) rx_push(3'(i + 4));
    bus_read(1'b1, rd);
    check("status_before_rst", rd, 3'b010);
    @(negedge clk);
    bus.rw_adr = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_tx_valid",  bus.tx_valid,  1'b0);
    check("midrst_tx_data",   bus.tx_data,   3'd0);
    check("midrst_rx_ready",  bus.rx_ready,  1'b1);
    check("midrst_status",    bus.read_data, 3'b000);
    check("midrst_rx_count",  bus.rx_count,  4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against a queue-level model
    err_m = 1'b0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      rdy_lim = ((cyc / 100) % 2 == 0) ? 1 : 3;
      vld_lim = ((cyc / 150) % 2 == 0) ? 3 : 1;
      op = $urandom_range(0, 9);
      bus.do_write = (op <= 3);
      bus.do_read  = (op >= 4 && op <= 7);
      bus.rw_adr   = (op == 3 || op == 7) ? 1'b1 : (op <= 6 ? 1'b0 : 1'($urandom_range(0, 1)));
      bus.w_data   = 3'($urandom_range(0, 7));
      bus.tx_ready = ($urandom_range(0, 3) < rdy_lim);
      bus.rx_valid = ($urandom_range(0, 3) < vld_lim);
      bus.rx_data  = 3'($urandom_range(0, 7));
      #1;
      exp_txv = (tx_m.size() != 0);
      exp_rxr = (rx_m.size() < DEPTH);
      stat    = {err_m, rx_m.size() != 0, tx_m.size() == DEPTH};
      check("rnd_tx_valid", bus.tx_valid, exp_txv);
      check("rnd_tx_data",  bus.tx_data,  exp_txv ? tx_m[0] : 3'd0);
      check("rnd_rx_ready", bus.rx_ready, exp_rxr);
      check("rnd_read_data", bus.read_data,
            bus.rw_adr ? stat : (rx_m.size() != 0 ? rx_m[0] : 3'd0));
      set_err = 1'b0;
      if (exp_txv && bus.tx_ready) void'(tx_m.pop_front());
      if (bus.do_write && !bus.rw_adr) begin
        if (tx_m.size() < DEPTH) tx_m.push_back(bus.w_data);
        else set_err = 1'b1;
      end
      if (bus.do_read && !bus.rw_adr) begin
        if (rx_m.size() == 0) set_err = 1'b1;
        else void'(rx_m.pop_front());
      end
      if (bus.rx_valid && exp_rxr) rx_m.push_back(bus.rx_data);
      if (set_err) err_m = 1'b1;
      else if (bus.do_write && bus.rw_adr && bus.w_data[2]) err_m = 1'b0;
    end
    @(negedge clk);
    bus.do_write = 1'b0;
    bus.do_read  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
